muldiv: RTL and testbench
=========================

# muldiv

Multi-cycle multiply/divide unit in the EX stage, beside the ALU; it takes the same A/B operands and keeps the architectural HI/LO registers. It executes MULT, MULTU, DIV and DIVU iteratively and raises busy so the hazard unit stalls dependent MFHI/MFLO and new mul/div instructions. HI/LO feed the EX result mux alongside the ALU output.

## Interface
- No parameters; datapath fixed at 32 bits.
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high.
- start  input  1  begin operation; sampled only in IDLE.
- op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start.
- A  input  32  multiplicand/dividend; also write data for mthi/mtlo.
- B  input  32  multiplier/divisor.
- mthi  input  1  write A into HI; honoured only in IDLE.
- mtlo  input  1  write A into LO; honoured only in IDLE.
- busy  output  1  high while an operation is in flight.
- done  output  1  one-cycle pulse, high in the first cycle new HI/LO are visible.
- hi  output  32  HI register.
- lo  output  32  LO register.

## Operation
- States: IDLE, PREP, RUN, FIX.
- **IDLE**
  - start=1 latches op, A, B; goes to PREP.
  - mthi/mtlo write HI/LO at the same edge, and may coincide with start.
  - A later result overwrites any mthi/mtlo value.
- **PREP** (1 cycle)
  - Signed ops: record the sign of A and B; replace each with its magnitude (abs(0x80000000) = 0x80000000 unsigned).
  - Unsigned ops: pass A and B unchanged.
  - Clear the 64-bit accumulator and the counter; go to RUN.
- **RUN** (exactly 32 cycles, counter 0..31)
  - Multiply: radix-2 shift-add over a 64-bit product.
  - Divide: restoring shift-subtract, 32-bit remainder plus 32-bit quotient.
  - Goes to FIX after count 31.
- **FIX** (1 cycle)
  - Applies sign correction, writes HI/LO, returns to IDLE.
- **Multiply results**
  - Signed: negate the 64-bit product iff sign(A)≠sign(B).
  - HI = product[63:32], LO = product[31:0].
- **Divide results**
  - Quotient truncates toward zero and goes to LO.
  - Remainder takes the sign of the dividend and goes to HI.
- **Divide by zero** (B=0, any sign): HI = original A, LO = 32'hFFFFFFFF; no exception.
- **Signed overflow**: 0x80000000 / 0xFFFFFFFF gives LO = 0x80000000, HI = 0.
- busy = (state ≠ IDLE).
- Requests ignored while busy:
  - start;
  - mthi/mtlo.
- reset at any time, including mid-operation:
  - state = IDLE;
  - HI = LO = 0;
  - busy = 0, done = 0;
  - the in-flight result is discarded.

## Timing
- Reset values: hi=0, lo=0, busy=0, done=0.
- start sampled at edge k:
  - busy high from edge k through edge k+34, i.e. 34 cycles;
  - HI/LO updated at edge k+34;
  - done high between edges k+34 and k+35.
- busy falls at the same edge that raises done, so a new start in the done cycle is accepted.
- mthi/mtlo take effect at the sampling edge; hi/lo are registered outputs with no combinational path from inputs.
- Fixed latency of 34 cycles for all ops and all operand values; no early termination.

## Test plan
- **MULT**: A=0xFFFFFFFD (−3), B=5 -> after 34 cycles HI=0xFFFFFFFF, LO=0xFFFFFFF1, one-cycle done.
- **MULTU**: A=B=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
- **DIV**, checking signs and truncation:
  - A=0xFFFFFFF9 (−7), B=2 -> LO=0xFFFFFFFD (−3), HI=0xFFFFFFFF (−1).
  - A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0.
- **DIVU by zero**: A=100, B=0 -> HI=100, LO=0xFFFFFFFF.
- **Ignored requests**:
  - start with A=7, B=3, op=DIVU;
  - in cycle 5 pulse start (op=MULT) plus mthi with A=0x1234;
  - required: HI=1, LO=2 at completion; busy exactly 34 cycles.
- **Reset mid-run and back-to-back**:
  - reset in RUN cycle 10 -> next cycle busy=0, HI=LO=0, done never pulses;
  - then back-to-back starts (second start in the done cycle) -> both results correct, 34 cycles apart.

Source files
------------

// File: rtl/muldiv.sv
// Iterative 32-bit multiply/divide unit holding the architectural HI/LO registers.
// Fixed 34-cycle latency: one prep cycle, 32 shift cycles, one sign-fix cycle.
module muldiv (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        mthi,
    input  logic        mtlo,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {IDLE = 2'd0, PREP = 2'd1, RUN = 2'd2, FIX = 2'd3} state_t;

    state_t      state_q, state_d;
    logic [1:0]  op_q, op_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] mag_a_q, mag_a_d;
    logic        sign_a_q, sign_a_d;
    logic        sign_b_q, sign_b_d;
    logic [63:0] acc_q, acc_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic [32:0] mul_sum_s;
    logic [32:0] rem_shift_s;
    logic        div_ge_s;
    logic [31:0] div_sub_s;
    logic [63:0] prod_s;
    logic [31:0] quo_s;
    logic [31:0] rem_s;
    logic [31:0] res_hi_s;
    logic [31:0] res_lo_s;

    function automatic logic [31:0] abs32(input logic [31:0] v);
        abs32 = v[31] ? (~v + 32'd1) : v;
    endfunction

    // One iteration of shift-add (multiply) and restoring shift-subtract (divide).
    always_comb begin
        mul_sum_s   = {1'b0, acc_q[63:32]} + {1'b0, (b_q[0] ? mag_a_q : 32'd0)};
        rem_shift_s = {acc_q[63:32], mag_a_q[31]};
        div_ge_s    = (rem_shift_s >= {1'b0, b_q});
        div_sub_s   = rem_shift_s[31:0] - b_q;
    end

    // Sign correction and divide-by-zero override applied in FIX.
    always_comb begin
        prod_s = (sign_a_q ^ sign_b_q) ? (~acc_q + 64'd1) : acc_q;
        quo_s  = (sign_a_q ^ sign_b_q) ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
        rem_s  = sign_a_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];
        if (!op_q[1]) begin
            res_hi_s = prod_s[63:32];
            res_lo_s = prod_s[31:0];
        end else if (b_q == 32'd0) begin
            res_hi_s = a_q;
            res_lo_s = 32'hFFFF_FFFF;
        end else begin
            res_hi_s = rem_s;
            res_lo_s = quo_s;
        end
    end

    // Next-state logic for the controller and datapath.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        mag_a_d  = mag_a_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (mthi) begin
                    hi_d = A;
                end else begin
                    hi_d = hi_q;
                end
                if (mtlo) begin
                    lo_d = A;
                end else begin
                    lo_d = lo_q;
                end
                if (start) begin
                    op_d    = op;
                    a_d     = A;
                    b_d     = B;
                    busy_d  = 1'b1;
                    state_d = PREP;
                end else begin
                    state_d = IDLE;
                end
            end
            PREP: begin
                if (!op_q[0]) begin
                    sign_a_d = a_q[31];
                    sign_b_d = b_q[31];
                    mag_a_d  = abs32(a_q);
                    b_d      = abs32(b_q);
                end else begin
                    sign_a_d = 1'b0;
                    sign_b_d = 1'b0;
                    mag_a_d  = a_q;
                    b_d      = b_q;
                end
                acc_d   = 64'd0;
                cnt_d   = 5'd0;
                state_d = RUN;
            end
            RUN: begin
                // Divide shifts dividend bits out of mag_a; multiply consumes multiplier bits from b.
                if (op_q[1]) begin
                    acc_d   = div_ge_s ? {div_sub_s, acc_q[30:0], 1'b1}
                                       : {rem_shift_s[31:0], acc_q[30:0], 1'b0};
                    mag_a_d = {mag_a_q[30:0], 1'b0};
                end else begin
                    acc_d   = {mul_sum_s, acc_q[31:1]};
                    b_d     = {1'b0, b_q[31:1]};
                end
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = FIX;
                end else begin
                    state_d = RUN;
                end
            end
            FIX: begin
                hi_d    = res_hi_s;
                lo_d    = res_lo_s;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            op_q     <= 2'd0;
            a_q      <= 32'd0;
            b_q      <= 32'd0;
            mag_a_q  <= 32'd0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            acc_q    <= 64'd0;
            cnt_q    <= 5'd0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            mag_a_q  <= mag_a_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv.sv
// Self-checking bench for muldiv: directed corner cases plus random operations
// compared against an arithmetic reference model.
module tb_muldiv;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        mthi;
    logic        mtlo;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    muldiv dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .A     (A),
        .B     (B),
        .mthi  (mthi),
        .mtlo  (mtlo),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: {HI, LO} from plain signed/unsigned arithmetic.
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint      sa;
        longint      sb;
        longint      q;
        longint      r;
        logic [63:0] p;
        logic [63:0] qv;
        logic [63:0] rv;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            2'b00: begin
                p = sa * sb;
                return p;
            end
            2'b01: begin
                p = {32'd0, a} * {32'd0, b};
                return p;
            end
            2'b10: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                q  = sa / sb;
                r  = sa % sb;
                qv = q;
                rv = r;
                return {rv[31:0], qv[31:0]};
            end
            default: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h8000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'd0;
            3: return 32'd1;
            default: return $urandom();
        endcase
    endfunction

    // Drive start for one edge; mt = {mthi, mtlo} written at the same edge.
    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input logic [1:0] mt);
        @(negedge clk);
        start = 1'b1; op = o; A = a; B = b; mthi = mt[1]; mtlo = mt[0];
        @(posedge clk);
        #1;
        start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        check("start_ack", {busy, done}, 2'b10);
        if (mt[1]) check("mthi_with_start", hi, a);
        if (mt[0]) check("mtlo_with_start", lo, a);
    endtask

    // Follow an accepted op through its 34-cycle latency; optionally poke ignored requests.
    task automatic finish_op(input string tag, input logic [63:0] exp, input bit inject);
        int bad = 0;
        for (int i = 1; i <= 33; i++) begin
            @(posedge clk);
            #1;
            if (busy !== 1'b1 || done !== 1'b0) bad++;
            if (inject && i == 4) begin
                start = 1'b1; op = 2'b00; A = 32'h1234; mthi = 1'b1;
            end else begin
                start = 1'b0; mthi = 1'b0;
            end
        end
        check({tag, "_busy_hold"}, bad, 0);
        @(posedge clk);
        #1;
        check({tag, "_busy_done"}, {busy, done}, 2'b01);
        check({tag, "_hilo"}, {hi, lo}, exp);
    endtask

    initial begin
        int nodone;
        logic [1:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;
        reset = 1'b1; start = 1'b0; op = 2'b00; A = 32'd0; B = 32'd0; mthi = 1'b0; mtlo = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check("reset_state", {busy, done, hi, lo}, 66'd0);

        @(negedge clk);
        A = 32'hCAFE_0001; mthi = 1'b1;
        @(posedge clk);
        #1;
        mthi = 1'b0;
        check("mthi_idle", {hi, lo}, {32'hCAFE_0001, 32'd0});
        @(negedge clk);
        A = 32'hBEEF_0002; mtlo = 1'b1;
        @(posedge clk);
        #1;
        mtlo = 1'b0;
        check("mtlo_idle", {hi, lo}, {32'hCAFE_0001, 32'hBEEF_0002});

        issue(2'b00, 32'hFFFF_FFFD, 32'd5, 2'b00);
        finish_op("mult_neg3x5", 64'hFFFF_FFFF_FFFF_FFF1, 1'b0);
        issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b00);
        finish_op("multu_max", 64'hFFFF_FFFE_0000_0001, 1'b0);
        issue(2'b10, 32'hFFFF_FFF9, 32'd2, 2'b00);
        finish_op("div_neg7by2", 64'hFFFF_FFFF_FFFF_FFFD, 1'b0);
        issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 2'b00);
        finish_op("div_overflow", 64'h0000_0000_8000_0000, 1'b0);
        issue(2'b11, 32'd100, 32'd0, 2'b01);
        finish_op("divu_by_zero", {32'd100, 32'hFFFF_FFFF}, 1'b0);
        issue(2'b10, 32'hFFFF_FF9C, 32'd0, 2'b00);
        finish_op("div_by_zero_neg", {32'hFFFF_FF9C, 32'hFFFF_FFFF}, 1'b0);
        issue(2'b11, 32'd7, 32'd3, 2'b00);
        finish_op("ignored_requests", {32'd1, 32'd2}, 1'b1);

        // Reset during RUN count 10 must drop everything with no done pulse.
        issue(2'b00, 32'd3, 32'd5, 2'b11);
        repeat (11) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("midrun_reset", {busy, done, hi, lo}, 66'd0);
        nodone = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done !== 1'b0 || busy !== 1'b0) nodone++;
        end
        check("no_done_after_reset", nodone, 0);

        issue(2'b00, 32'd123456, 32'hFFFF_FF00, 2'b00);
        finish_op("b2b_first", model(2'b00, 32'd123456, 32'hFFFF_FF00), 1'b0);
        issue(2'b11, 32'hDEAD_BEEF, 32'd1000, 2'b00);
        finish_op("b2b_second", model(2'b11, 32'hDEAD_BEEF, 32'd1000), 1'b0);

        for (int n = 0; n < 150; n++) begin
            ro = 2'($urandom_range(0, 3));
            ra = pick();
            rb = pick();
            issue(ro, ra, rb, 2'b00);
            finish_op($sformatf("rand%0d_op%0d", n, ro), model(ro, ra, rb), 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
